// File: rtl/fmap_rd_pkg.sv
//==============================================================================
// fmap_rd_pkg
//   Shared types and constants for the feature-map read responder.
//   - ARBURST_INCR : the only legal burst encoding
//   - rsp_state_t  : responder FSM states
//   - ar_req_t     : one queued read request {addr, burst}
//==============================================================================
`default_nettype none

package fmap_rd_pkg;

  localparam logic [3:0] ARBURST_INCR = 4'b0001;

  // Request address field width held in the FIFO. Only the low
  // $clog2(MEM_DEPTH) bits are needed to serve a burst because addresses wrap.
  localparam int REQ_AW = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LAT  = 2'd1,
    DATA = 2'd2
  } rsp_state_t;

  typedef struct packed {
    logic [REQ_AW-1:0] addr;
    logic [3:0]        burst;
  } ar_req_t;

endpackage

`default_nettype wire

// File: rtl/fmap_req_fifo.sv
//==============================================================================
// fmap_req_fifo
//   Small synchronous FIFO holding pending burst requests.
//   Ports:
//     clk, rst_n       clock, asynchronous active-low reset
//     push, push_data  write strobe / entry
//     pop,  pop_data   read strobe / head entry (valid while !empty)
//     full, empty      occupancy flags
//     count            number of stored entries
//==============================================================================
`default_nettype none

module fmap_req_fifo #(
  parameter int W     = 36,
  parameter int DEPTH = 2,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  pop_data,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  store [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  // Pointers wrap explicitly so non-power-of-two depths also index safely.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (push) store[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign pop_data = store[rd_ptr];
  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);

endmodule

`default_nettype wire

// File: rtl/fmap_rd_responder.sv
//==============================================================================
// fmap_rd_responder
//   Read-side responder for the feature-map fetch path. Accepts burst read
//   requests (word addresses, INCR only) and streams BURST beats back-to-back
//   from an internal synchronous memory that is loaded through a backdoor.
//   Ports:
//     clk, rst_n                 clock, asynchronous active-low reset
//     araddr, arvalid, arready   request channel (arready registered)
//     arburst                    burst type, 4'b0001 = INCR
//     rdata, rvalid, rlast       beat channel, no back-pressure
//     ld_en, ld_addr, ld_data    backdoor memory write
//     err                        sticky illegal-burst / out-of-range flag
//     busy                       burst in flight or requests pending
//   Optional build macro:
//     FMAP_RD_GAP_EN  insert a one-cycle bubble after every 8th beat
//==============================================================================
`default_nettype none

module fmap_rd_responder
  import fmap_rd_pkg::*;
#(
  parameter int DW        = 32,
  parameter int AW        = 32,
  parameter int BURST     = 32,
  parameter int MEM_DEPTH = 4096,
  parameter int RD_LAT    = 2,
  parameter int OUTSTD    = 2,
  localparam int MIW      = $clog2(MEM_DEPTH)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [AW-1:0]  araddr,
  input  logic           arvalid,
  output logic           arready,
  input  logic [3:0]     arburst,
  output logic [DW-1:0]  rdata,
  output logic           rvalid,
  output logic           rlast,
  input  logic           ld_en,
  input  logic [MIW-1:0] ld_addr,
  input  logic [DW-1:0]  ld_data,
  output logic           err,
  output logic           busy
);

  localparam int BW = (BURST > 1) ? $clog2(BURST) : 1;
  localparam int LW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam int CW = $clog2(OUTSTD + 1);

  // Request queue
  logic          push;
  logic          pop;
  ar_req_t       push_req;
  ar_req_t       head;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [CW:0]   count_after;

  assign push     = arvalid && arready;
  assign push_req = '{addr: REQ_AW'(araddr), burst: arburst};

  fmap_req_fifo #(
    .W     ($bits(ar_req_t)),
    .DEPTH (OUTSTD)
  ) u_req_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_req),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // arready looks ahead at the post-edge occupancy so it is already low in
  // the cycle after the push that fills the FIFO.
  assign count_after = {1'b0, fifo_count} + (CW+1)'(push) - (CW+1)'(pop);

  // Acceptance check on the incoming request
  logic [AW:0] end_addr;
  logic        bad_req;

  assign end_addr = {1'b0, araddr} + (AW+1)'(BURST);
  assign bad_req  = (arburst != ARBURST_INCR) || (end_addr > (AW+1)'(MEM_DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arready <= 1'b0;
      err     <= 1'b0;
    end else begin
      arready <= (count_after < (CW+1)'(OUTSTD));
      if (push && bad_req) err <= 1'b1;
    end
  end

  // Memory array: no reset, survives rst_n.
  logic [DW-1:0] mem [MEM_DEPTH];

  always_ff @(posedge clk) begin
    if (ld_en) mem[ld_addr] <= ld_data;
  end

  // Burst FSM
  rsp_state_t     state, state_n;
  logic [LW-1:0]  lat_cnt, lat_cnt_n;
  logic [MIW-1:0] beat_addr, beat_addr_n;
  logic [BW-1:0]  beat_cnt, beat_cnt_n;
  logic           start;
  logic           load;
  logic           gap;

`ifdef FMAP_RD_GAP_EN
  logic gap_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) gap <= 1'b0;
    else        gap <= gap_n;
  end
`else
  assign gap = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      lat_cnt   <= '0;
      beat_addr <= '0;
      beat_cnt  <= '0;
    end else begin
      state     <= state_n;
      lat_cnt   <= lat_cnt_n;
      beat_addr <= beat_addr_n;
      beat_cnt  <= beat_cnt_n;
    end
  end

  // beat_addr/beat_cnt always name the beat presented while in DATA; the
  // next-state value of beat_addr is therefore the address to read now.
  always_comb begin
    state_n     = state;
    lat_cnt_n   = lat_cnt;
    beat_addr_n = beat_addr;
    beat_cnt_n  = beat_cnt;
    start       = 1'b0;
    pop         = 1'b0;
`ifdef FMAP_RD_GAP_EN
    gap_n       = 1'b0;
`endif
    case (state)
      IDLE: start = !fifo_empty;
      LAT: begin
        if (lat_cnt == '0) state_n = DATA;
        else               lat_cnt_n = lat_cnt - 1'b1;
      end
      DATA: begin
        if (gap) begin
          // bubble cycle: hold the pending beat
        end else if (beat_cnt == BW'(BURST - 1)) begin
          state_n = IDLE;
          start   = !fifo_empty;
        end else begin
          beat_addr_n = beat_addr + 1'b1;
          beat_cnt_n  = beat_cnt + 1'b1;
`ifdef FMAP_RD_GAP_EN
          gap_n       = (beat_cnt[2:0] == 3'd7);
`endif
        end
      end
      default: state_n = IDLE;
    endcase

    if (start) begin
      pop         = 1'b1;
      state_n     = LAT;
      beat_addr_n = head.addr[MIW-1:0];
      beat_cnt_n  = '0;
      lat_cnt_n   = LW'(RD_LAT - 1);
    end

`ifdef FMAP_RD_GAP_EN
    load = (state_n == DATA) && !gap_n;
`else
    load = (state_n == DATA);
`endif
  end

  // Synchronous read one cycle ahead of the beat; a same-edge backdoor write
  // to the same word is not visible here (old data returned).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    rdata <= '0;
    else if (load) rdata <= mem[beat_addr_n];
  end

  assign rvalid = (state == DATA) && !gap;
  assign rlast  = rvalid && (beat_cnt == BW'(BURST - 1));
  assign busy   = (state != IDLE) || !fifo_empty;

  // Burst type and upper address bits are only needed at acceptance.
  logic unused_bits;
  assign unused_bits = ^{head.burst, head.addr[REQ_AW-1:MIW], fifo_full};

endmodule

`default_nettype wire

// File: tb/tb_fmap_rd_responder.sv
//==============================================================================
// tb_fmap_rd_responder
//   Directed self-checking bench for fmap_rd_responder (default parameters).
//   Honours FMAP_RD_GAP_EN when the design is built with it.
//==============================================================================
`default_nettype none

module tb_fmap_rd_responder;

`ifdef FMAP_RD_GAP_EN
  localparam int GAP_ON = 1;
`else
  localparam int GAP_ON = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] araddr = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [3:0]  arburst = 4'b0001;
  logic [31:0] rdata;
  logic        rvalid;
  logic        rlast;
  logic        ld_en = 1'b0;
  logic [11:0] ld_addr = '0;
  logic [31:0] ld_data = '0;
  logic        err;
  logic        busy;

  fmap_rd_responder dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .araddr  (araddr),
    .arvalid (arvalid),
    .arready (arready),
    .arburst (arburst),
    .rdata   (rdata),
    .rvalid  (rvalid),
    .rlast   (rlast),
    .ld_en   (ld_en),
    .ld_addr (ld_addr),
    .ld_data (ld_data),
    .err     (err),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] d;
    logic        l;
    int          c;
  } beat_t;

  beat_t q[$];

  always @(negedge clk) begin
    if (rvalid) q.push_back('{d: rdata, l: rlast, c: cyc});
  end

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request and hold it until accepted; acc = cycle of the accepting edge.
  task automatic send(input string tag, input logic [31:0] a, input logic [3:0] b, output int acc);
    int k;
    acc     = -1;
    araddr  = a;
    arburst = b;
    arvalid = 1'b1;
    for (k = 0; k < 200; k++) begin
      if (arready) begin
        tick();
        acc = cyc;
        break;
      end
      tick();
    end
    arvalid = 1'b0;
    chk({tag, "_accepted"}, (acc >= 0), 1'b1);
  endtask

  task automatic wait_done(input string tag);
    int k;
    for (k = 0; k < 400; k++) begin
      tick();
      if (!busy && !rvalid) break;
    end
    chk({tag, "_done"}, (k < 400), 1'b1);
  endtask

  // Count beats in q[first +: n] whose data differs from base+i (mod 4096 words).
  function automatic int data_bad(input int first, input int n, input int base);
    int bad = 0;
    for (int i = 0; i < n; i++) begin
      if (first + i >= q.size()) bad++;
      else if (q[first + i].d !== 32'((base + i) % 4096)) bad++;
    end
    return bad;
  endfunction

  // Count rlast positions that disagree with "every 32nd beat".
  function automatic int last_bad();
    int bad = 0;
    for (int i = 0; i < q.size(); i++) begin
      if (q[i].l !== ((i % 32) == 31)) bad++;
    end
    return bad;
  endfunction

  int acc0, acc1, acc2, acc3;
  int bad;
  int k5;

  initial begin
    // ---------------- reset state ----------------
    #1;
    chk("rst_arready", arready, 1'b0);
    chk("rst_rvalid",  rvalid,  1'b0);
    chk("rst_rlast",   rlast,   1'b0);
    chk("rst_rdata",   rdata,   32'h0);
    chk("rst_err",     err,     1'b0);
    chk("rst_busy",    busy,    1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("arready_after_rst", arready, 1'b1);

    // ---------------- backdoor load ----------------
    for (int i = 0; i < 64; i++) begin
      ld_en = 1'b1; ld_addr = 12'(i); ld_data = 32'(i);
      tick();
    end
    for (int i = 0; i < 16; i++) begin
      ld_en = 1'b1; ld_addr = 12'(4080 + i); ld_data = 32'hA000 + 32'(i);
      tick();
    end
    ld_en = 1'b0;

    // ---------------- T1: single burst ----------------
    q.delete();
    send("t1", 32'd0, 4'b0001, acc0);
    wait_done("t1");
    chk("t1_count", q.size(), 32);
    chk("t1_latency", (q.size() > 0) ? q[0].c - acc0 : -1, 3);
    chk("t1_data", data_bad(0, 32, 0), 0);
    chk("t1_rlast", last_bad(), 0);
    bad = 0;
    for (int i = 1; i < q.size(); i++) begin
      if (q[i].c - q[i-1].c != ((GAP_ON != 0 && (i % 8) == 0) ? 2 : 1)) bad++;
    end
    chk("t1_spacing", bad, 0);
    chk("t1_span", (q.size() == 32) ? q[31].c - q[0].c : -1, 31 + 3 * GAP_ON);
    chk("t1_err", err, 1'b0);

    // ---------------- T2: back-to-back requests ----------------
    q.delete();
    send("t2a", 32'd0, 4'b0001, acc0);
    send("t2b", 32'd32, 4'b0001, acc1);
    chk("t2_b2b_accept", acc1 - acc0, 1);
    wait_done("t2");
    chk("t2_count", q.size(), 64);
    chk("t2_data", data_bad(0, 64, 0), 0);
    chk("t2_rlast", last_bad(), 0);
    chk("t2_burst_gap", (q.size() == 64) ? q[32].c - q[31].c : -1, 3);

    // ---------------- T3: fill the request FIFO while a burst runs ----------------
    q.delete();
    send("t3a", 32'd0, 4'b0001, acc0);
    for (int k = 0; k < 20 && q.size() == 0; k++) tick();
    chk("t3_first_beat_seen", (q.size() > 0), 1'b1);
    send("t3b", 32'd32, 4'b0001, acc1);
    send("t3c", 32'd0, 4'b0001, acc2);
    chk("t3_c_b2b", acc2 - acc1, 1);
    chk("t3_arready_full", arready, 1'b0);
    chk("t3_busy", busy, 1'b1);
    send("t3d", 32'd32, 4'b0001, acc3);
    wait_done("t3");
    chk("t3_count", q.size(), 128);
    chk("t3_d_after_pop", (q.size() >= 32) ? acc3 - q[31].c : -1, 2);
    bad = data_bad(0, 32, 0) + data_bad(32, 32, 32) + data_bad(64, 32, 0) + data_bad(96, 32, 32);
    chk("t3_data", bad, 0);
    chk("t3_rlast", last_bad(), 0);

    // ---------------- T4: illegal burst, wrapping address ----------------
    q.delete();
    chk("t4_err_before", err, 1'b0);
    send("t4", 32'd4080, 4'b0010, acc0);
    chk("t4_err_rise", err, 1'b1);
    wait_done("t4");
    chk("t4_count", q.size(), 32);
    bad = 0;
    for (int i = 0; i < 32; i++) begin
      if (i >= q.size()) bad++;
      else if (q[i].d !== ((i < 16) ? 32'hA000 + 32'(i) : 32'(i - 16))) bad++;
    end
    chk("t4_wrap_data", bad, 0);
    chk("t4_err_sticky", err, 1'b1);

    // ---------------- T5: reset mid-burst ----------------
    q.delete();
    send("t5a", 32'd0, 4'b0001, acc0);
    for (k5 = 0; k5 < 100; k5++) begin
      tick();
      if (rvalid && rdata == 32'd10) break;
    end
    chk("t5_reached_beat10", (k5 < 100), 1'b1);
    rst_n = 1'b0;
    #1;
    chk("t5_rvalid_drop", rvalid, 1'b0);
    chk("t5_rlast_drop",  rlast,  1'b0);
    chk("t5_busy_drop",   busy,   1'b0);
    chk("t5_err_clear",   err,    1'b0);
    chk("t5_arready_rst", arready, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("t5_arready_back", arready, 1'b1);
    q.delete();
    send("t5b", 32'd32, 4'b0001, acc1);
    wait_done("t5");
    chk("t5_count", q.size(), 32);
    chk("t5_mem_kept", data_bad(0, 32, 32), 0);
    chk("t5_rlast", last_bad(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
